audio_bus_arbiter: RTL and testbench

AUDIO_BUS_ARBITER -- requirements
Module: audio_bus_arbiter

---
 rtl/audio_bus_pkg.sv | 20 ++
 rtl/audio_bus_arbiter_if.sv | 26 ++
 rtl/audio_bus_arbiter_rr_picker.sv | 38 +++
 rtl/audio_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_audio_bus_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_bus_pkg.sv
// rtl/audio_bus_pkg.sv - shared constants and types for the audio bus arbiter
//
// Holds the audio peripheral register map, the arbiter FSM state type and
// the default requester count used by audio_bus_arbiter.
package audio_bus_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 2;

    localparam logic [31:0] AUDIO_BASE_ADDR       = 32'h0000_3040;
    localparam logic [31:0] AUDIO_FIFO_SPACE_ADDR = 32'h0000_3044;
    localparam logic [31:0] AUDIO_LEFT_DATA_ADDR  = 32'h0000_3048;
    localparam logic [31:0] AUDIO_RIGHT_DATA_ADDR = 32'h0000_304C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/audio_bus_arbiter_if.sv
// rtl/audio_bus_arbiter_if.sv - Avalon-style master bus between arbiter and fabric
//
// Signals: bus_addr, bus_write_data, bus_byte_enable, bus_read, bus_write
// (master -> slave); bus_ack, bus_read_data (slave -> master).
// Modports: master (arbiter side), slave (fabric side).
interface audio_bus_arbiter_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic        bus_ack;
    logic [31:0] bus_read_data;

    modport master (
        output bus_addr, bus_write_data, bus_byte_enable, bus_read, bus_write,
        input  bus_ack, bus_read_data
    );

    modport slave (
        input  bus_addr, bus_write_data, bus_byte_enable, bus_read, bus_write,
        output bus_ack, bus_read_data
    );

endinterface

// File: rtl/audio_bus_arbiter_rr_picker.sv
// rtl/audio_bus_arbiter_rr_picker.sv - combinational round-robin winner select
//
// Ports: req (request vector), last_ptr (index of previous owner),
// winner (one-hot), winner_idx (binary index of winner), any_req.
// The search starts at last_ptr+1 and wraps modulo NUM_REQ.
module rr_picker #(
    parameter int  NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_req
);

    int idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        idx        = 0;
        any_req    = |req;
        // Scan from farthest to nearest so the nearest requester after the
        // previous owner is the last assignment and therefore wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                winner     = NUM_REQ'(1) << idx;
                winner_idx = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/audio_bus_arbiter.sv
// rtl/audio_bus_arbiter.sv - round-robin arbiter sharing one Avalon master
//
// Ports: clk, rst (sync active-high); req_rd/req_wr/req_addr/req_wdata/req_be
// per requester; gnt (one-hot owner), done (completion pulse), rdata (read
// data valid with done), timeout_err (sticky); bus (Avalon master modport).
// Optional feature: define AUDIO_BUS_ARB_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES wait cycles without bus_ack.
module audio_bus_arbiter
    import audio_bus_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_rd,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_be,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            rdata,
    output logic                   timeout_err,
    audio_bus_arbiter_if.master    bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [PTR_W-1:0]   last_owner;
    logic [PTR_W-1:0]   owner;
    logic               op_is_read;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (req_rd | req_wr),
        .last_ptr   (last_owner),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

`ifdef AUDIO_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            last_owner           <= PTR_W'(NUM_REQ - 1);
            owner                <= '0;
            op_is_read           <= 1'b0;
            gnt                  <= '0;
            done                 <= '0;
            rdata                <= '0;
            bus.bus_read         <= 1'b0;
            bus.bus_write        <= 1'b0;
            bus.bus_addr         <= '0;
            bus.bus_write_data   <= '0;
            bus.bus_byte_enable  <= '0;
`ifdef AUDIO_BUS_ARB_TIMEOUT_EN
            wait_cnt             <= '0;
            timeout_err          <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt                 <= pick_onehot;
                        owner               <= pick_idx;
                        // A read wins over a simultaneous write; the write
                        // stays pending on the level request.
                        op_is_read          <= req_rd[pick_idx];
                        bus.bus_addr        <= req_addr[int'(pick_idx)*32 +: 32];
                        bus.bus_write_data  <= req_wdata[int'(pick_idx)*32 +: 32];
                        bus.bus_byte_enable <= req_be[int'(pick_idx)*4 +: 4];
                        state               <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.bus_read  <= op_is_read;
                    bus.bus_write <= ~op_is_read;
`ifdef AUDIO_BUS_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        bus.bus_read  <= 1'b0;
                        bus.bus_write <= 1'b0;
                        if (op_is_read) begin
                            rdata <= bus.bus_read_data;
                        end
                        done[owner]   <= 1'b1;
                        gnt           <= '0;
                        last_owner    <= owner;
                        state         <= ST_IDLE;
                    end
`ifdef AUDIO_BUS_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.bus_read  <= 1'b0;
                        bus.bus_write <= 1'b0;
                        rdata         <= '0;
                        done[owner]   <= 1'b1;
                        gnt           <= '0;
                        last_owner    <= owner;
                        timeout_err   <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_bus_arbiter.sv
// tb/tb_audio_bus_arbiter.sv - scoreboard bench for audio_bus_arbiter
module tb_audio_bus_arbiter;
    import audio_bus_pkg::*;

    localparam int NR = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_rd, req_wr, gnt, done;
    logic [32*NR-1:0]  req_addr, req_wdata;
    logic [4*NR-1:0]   req_be;
    logic [31:0]       rdata;
    logic              timeout_err;

    audio_bus_arbiter_if bus_if ();

    audio_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .timeout_err (timeout_err),
        .bus         (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          slen;
    } exp_t;

    exp_t exp_q[$];
    int   tot = 0;
    int   bad = 0;
    bit   ack_en = 1'b1;
    int   ack_delay = 0;

    function automatic void push_exp(input int owner, input bit is_rd, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be,
                                     input logic [31:0] rd, input int slen);
        exp_t e;
        e.owner = owner; e.is_rd = is_rd; e.addr = addr; e.wdata = wdata;
        e.be = be; e.rdata = rd; e.slen = slen;
        exp_q.push_back(e);
    endfunction

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_addr[i*32 +: 32] = addr;
        req_wdata[i*32 +: 32] = wd;
        req_be[i*4 +: 4] = be;
    endtask

    task automatic wait_done(input int idx, input int budget, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        tot++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no done[%0d] within %0d cycles, required a pulse", tag, idx, budget);
        end
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus_if.bus_read || bus_if.bus_write) begin
                ok = 1'b1;
                break;
            end
        end
        tot++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no bus strobe within %0d cycles, required a strobe", tag, budget);
        end
    endtask

    // Avalon responder: acks after ack_delay full wait cycles.
    initial begin
        int scnt = 0;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_read_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && ack_en && (bus_if.bus_read || bus_if.bus_write)) begin
                scnt++;
                if (scnt == ack_delay + 1) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_read_data = (exp_q.size() != 0) ? exp_q[0].rdata : 32'hBAD0_BAD0;
                end else begin
                    bus_if.bus_ack = 1'b0;
                end
            end else begin
                bus_if.bus_ack = 1'b0;
                if (!(bus_if.bus_read || bus_if.bus_write) || rst) scnt = 0;
            end
        end
    end

    // Monitor: checks each issued transaction and each done pulse against the scoreboard.
    initial begin
        int          slen = 0;
        logic [31:0] h_addr, h_wd;
        logic [3:0]  h_be;
        logic        h_rd, h_wr;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                slen = 0;
            end else begin
                tot++;
                if ($countones(gnt) > 1 || (bus_if.bus_read && bus_if.bus_write)) begin
                    bad++;
                    $display("FAIL exclusive: gnt=%b rd=%b wr=%b, required one owner/one strobe",
                             gnt, bus_if.bus_read, bus_if.bus_write);
                end
                if (bus_if.bus_read || bus_if.bus_write) begin
                    tot++;
                    if (slen == 0) begin
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL issue: strobe addr=%h with empty scoreboard", bus_if.bus_addr);
                        end else if (bus_if.bus_addr !== exp_q[0].addr ||
                                     bus_if.bus_read !== exp_q[0].is_rd ||
                                     bus_if.bus_write !== !exp_q[0].is_rd ||
                                     gnt !== (NR'(1) << exp_q[0].owner) ||
                                     (!exp_q[0].is_rd && (bus_if.bus_write_data !== exp_q[0].wdata ||
                                                          bus_if.bus_byte_enable !== exp_q[0].be))) begin
                            bad++;
                            $display("FAIL issue: got addr=%h rd=%b wr=%b gnt=%b wd=%h be=%h, required addr=%h rd=%b owner=%0d wd=%h be=%h",
                                     bus_if.bus_addr, bus_if.bus_read, bus_if.bus_write, gnt,
                                     bus_if.bus_write_data, bus_if.bus_byte_enable, exp_q[0].addr,
                                     exp_q[0].is_rd, exp_q[0].owner, exp_q[0].wdata, exp_q[0].be);
                        end
                        h_addr = bus_if.bus_addr; h_wd = bus_if.bus_write_data;
                        h_be = bus_if.bus_byte_enable; h_rd = bus_if.bus_read; h_wr = bus_if.bus_write;
                    end else if (bus_if.bus_addr !== h_addr || bus_if.bus_write_data !== h_wd ||
                                 bus_if.bus_byte_enable !== h_be || bus_if.bus_read !== h_rd ||
                                 bus_if.bus_write !== h_wr) begin
                        bad++;
                        $display("FAIL stable: got addr=%h wd=%h be=%h, required addr=%h wd=%h be=%h",
                                 bus_if.bus_addr, bus_if.bus_write_data, bus_if.bus_byte_enable,
                                 h_addr, h_wd, h_be);
                    end
                    slen++;
                end
                if (done !== '0) begin
                    tot++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL done: got done=%b with empty scoreboard", done);
                    end else begin
                        e = exp_q.pop_front();
                        if (done !== (NR'(1) << e.owner) || gnt !== '0 || slen != e.slen ||
                            (e.is_rd && rdata !== e.rdata)) begin
                            bad++;
                            $display("FAIL done: got done=%b gnt=%b strobe_cycles=%0d rdata=%h, required owner=%0d gnt=0 strobe_cycles=%0d rdata=%h",
                                     done, gnt, slen, rdata, e.owner, e.slen, e.rdata);
                        end
                    end
                    slen = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tot++;
        if ({gnt, done, bus_if.bus_read, bus_if.bus_write, bus_if.bus_addr, bus_if.bus_write_data,
             bus_if.bus_byte_enable, rdata, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset: gnt=%b done=%b rd=%b wr=%b addr=%h wd=%h be=%h rdata=%h to=%b, required all 0",
                     gnt, done, bus_if.bus_read, bus_if.bus_write, bus_if.bus_addr,
                     bus_if.bus_write_data, bus_if.bus_byte_enable, rdata, timeout_err);
        end
    endtask

    task automatic test_single_read();
        ack_delay = 2;
        push_exp(0, 1'b1, AUDIO_FIFO_SPACE_ADDR, 32'h0, 4'h0, 32'h7F00_0010, 3);
        set_req(0, 1'b1, 1'b0, AUDIO_FIFO_SPACE_ADDR, 32'h0, 4'hF);
        wait_done(0, 20, "single_read");
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tot++;
        if (rdata !== 32'h7F00_0010) begin
            bad++;
            $display("FAIL single_read rdata: got %h required 7f000010", rdata);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        push_exp(0, 1'b0, AUDIO_LEFT_DATA_ADDR, 32'h0000_00A0, 4'h3, 32'h0, 1);
        push_exp(1, 1'b0, AUDIO_RIGHT_DATA_ADDR, 32'h0000_00B1, 4'hC, 32'h0, 1);
        set_req(0, 1'b0, 1'b1, AUDIO_LEFT_DATA_ADDR, 32'h0000_00A0, 4'h3);
        set_req(1, 1'b0, 1'b1, AUDIO_RIGHT_DATA_ADDR, 32'h0000_00B1, 4'hC);
        wait_done(0, 20, "contention_0");
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        tot++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL contention_gap: gnt one cycle after done got %b required 10", gnt);
        end
        wait_done(1, 20, "contention_1");
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_fairness();
        int n = 0, c0 = 0, c1 = 0;
        ack_delay = 1;
        for (int i = 0; i < 10; i++) begin
            push_exp(i % 2, 1'b0, (i % 2 == 0) ? AUDIO_LEFT_DATA_ADDR : AUDIO_RIGHT_DATA_ADDR,
                     32'h100 + (i % 2), 4'hF, 32'h0, 2);
        end
        set_req(0, 1'b0, 1'b1, AUDIO_LEFT_DATA_ADDR, 32'h100, 4'hF);
        set_req(1, 1'b0, 1'b1, AUDIO_RIGHT_DATA_ADDR, 32'h101, 4'hF);
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (done[0]) c0++;
            if (done[1]) c1++;
            if (done !== '0) n++;
        end
        req_wr = '0;
        tot++;
        if (c0 != 5 || c1 != 5) begin
            bad++;
            $display("FAIL fairness: got %0d/%0d grants, required 5/5", c0, c1);
        end
    endtask

    task automatic test_write_path();
        ack_delay = 3;
        push_exp(1, 1'b0, AUDIO_LEFT_DATA_ADDR, 32'h1234_5678, 4'hF, 32'h0, 4);
        set_req(1, 1'b0, 1'b1, AUDIO_LEFT_DATA_ADDR, 32'h1234_5678, 4'hF);
        wait_done(1, 20, "write_path");
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_read_over_write();
        ack_delay = 0;
        push_exp(0, 1'b1, AUDIO_RIGHT_DATA_ADDR, 32'h5555_0000, 4'h1, 32'hA5A5_0001, 1);
        push_exp(0, 1'b0, AUDIO_RIGHT_DATA_ADDR, 32'h5555_0000, 4'h1, 32'hDEAD_BEEF, 1);
        set_req(0, 1'b1, 1'b1, AUDIO_RIGHT_DATA_ADDR, 32'h5555_0000, 4'h1);
        wait_done(0, 20, "rd_over_wr_read");
        req_rd[0] = 1'b0;
        wait_done(0, 20, "rd_over_wr_write");
        req_wr[0] = 1'b0;
        tot++;
        if (rdata !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL rd_over_wr rdata: got %h required a5a50001 (write must not update)", rdata);
        end
    endtask

    task automatic test_deassert();
        ack_delay = 4;
        push_exp(1, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0BAD_CAFE, 5);
        set_req(1, 1'b1, 1'b0, AUDIO_BASE_ADDR, 32'h0, 4'h0);
        wait_strobe(10, "deassert");
        req_rd[1] = 1'b0;
        wait_done(1, 20, "deassert");
    endtask

    task automatic test_reset_mid_wait();
        ack_en = 1'b0;
        push_exp(1, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0, 0);
        set_req(1, 1'b1, 1'b0, AUDIO_BASE_ADDR, 32'h0, 4'h0);
        wait_strobe(10, "reset_mid_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tot++;
        if (bus_if.bus_read !== 1'b0 || done !== '0 || gnt !== '0) begin
            bad++;
            $display("FAIL reset_mid_wait: got rd=%b done=%b gnt=%b, required 0/00/00",
                     bus_if.bus_read, done, gnt);
        end
        rst = 1'b0;
        exp_q.delete();
        ack_en = 1'b1;
        ack_delay = 0;
        push_exp(0, 1'b1, AUDIO_FIFO_SPACE_ADDR, 32'h0, 4'h0, 32'h0000_0020, 1);
        push_exp(1, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0000_0021, 1);
        set_req(0, 1'b1, 1'b0, AUDIO_FIFO_SPACE_ADDR, 32'h0, 4'h0);
        wait_done(0, 20, "after_reset_0");
        req_rd[0] = 1'b0;
        wait_done(1, 20, "after_reset_1");
        req_rd[1] = 1'b0;
    endtask

`ifdef AUDIO_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        ack_en = 1'b0;
        push_exp(0, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0, TO);
        set_req(0, 1'b1, 1'b0, AUDIO_BASE_ADDR, 32'h0, 4'h0);
        wait_done(0, 40, "timeout");
        req_rd[0] = 1'b0;
        tot++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err: got %b required 1", timeout_err);
        end
        ack_en = 1'b1;
        ack_delay = 0;
        push_exp(0, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0000_0011, 1);
        set_req(0, 1'b1, 1'b0, AUDIO_BASE_ADDR, 32'h0, 4'h0);
        wait_done(0, 20, "after_timeout");
        req_rd[0] = 1'b0;
        tot++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b required 1", timeout_err);
        end
    endtask
`else
    task automatic test_timeout();
        bit saw_done = 1'b0;
        ack_en = 1'b0;
        push_exp(0, 1'b1, AUDIO_BASE_ADDR, 32'h0, 4'h0, 32'h0, 0);
        set_req(0, 1'b1, 1'b0, AUDIO_BASE_ADDR, 32'h0, 4'h0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done !== '0) saw_done = 1'b1;
        end
        tot++;
        if (saw_done || bus_if.bus_read !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: got done_seen=%b rd=%b to=%b, required 0/1/0",
                     saw_done, bus_if.bus_read, timeout_err);
        end
        req_rd[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ack_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_write_path();
        test_read_over_write();
        test_deassert();
        test_reset_mid_wait();
        test_timeout();
        repeat (3) @(negedge clk);
        tot++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected transactions never completed, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
